// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one registered external memory bus between the
// instruction prefetch port (I, read-only) and the load/store port (D).
`timescale 1ns/1ps

module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    // instruction prefetch port
    input  logic [18:0] i_addr,
    input  logic        i_access,
    output logic        i_ack,
    output logic [15:0] i_data_in,
    // load/store port
    input  logic [18:0] d_addr,
    input  logic [15:0] d_data_out,
    input  logic        d_wr_en,
    input  logic [1:0]  d_bytesel,
    input  logic        d_lock,
    input  logic        d_access,
    output logic        d_ack,
    output logic [15:0] d_data_in,
    // external memory bus
    output logic [18:0] m_addr,
    output logic [15:0] m_data_out,
    output logic        m_wr_en,
    output logic [1:0]  m_bytesel,
    output logic        m_access,
    input  logic        m_ack,
    input  logic [15:0] m_data_in
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SERVE_I,
        ST_SERVE_D,
        ST_HOLD_D
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_starve_cnt;
    logic [3:0]  w_next_starve_cnt;
    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_done;

    logic        r_m_access;
    logic [18:0] r_m_addr;
    logic [15:0] r_m_data_out;
    logic        r_m_wr_en;
    logic [1:0]  r_m_bytesel;

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_grant_i         = 1'b0;
        w_grant_d         = 1'b0;
        w_done            = 1'b0;
        w_next_state      = r_state;
        w_next_starve_cnt = r_starve_cnt;

        unique case (r_state)
            ST_IDLE: begin
                if (!i_access) begin
                    w_next_starve_cnt = '0;
                end
                if (d_access && (!i_access || (r_starve_cnt < LIMIT))) begin
                    w_grant_d = 1'b1;
                end else if (i_access) begin
                    w_grant_i = 1'b1;
                end
            end
            ST_SERVE_I: begin
                if (m_ack) begin
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_SERVE_D: begin
                if (m_ack) begin
                    w_done       = 1'b1;
                    w_next_state = d_lock ? ST_HOLD_D : ST_IDLE;
                end
            end
            ST_HOLD_D: begin
                // A locked split access keeps the bus for D; a new request beats a lock drop.
                if (d_access) begin
                    w_grant_d = 1'b1;
                end else if (!d_lock) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        if (w_grant_d) begin
            w_next_state = ST_SERVE_D;
            if (i_access && (r_starve_cnt < LIMIT)) begin
                w_next_starve_cnt = r_starve_cnt + 4'd1;
            end
        end
        if (w_grant_i) begin
            w_next_state      = ST_SERVE_I;
            w_next_starve_cnt = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_next_state;
            r_starve_cnt <= w_next_starve_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m_access   <= 1'b0;
            r_m_addr     <= '0;
            r_m_data_out <= '0;
            r_m_wr_en    <= 1'b0;
            r_m_bytesel  <= '0;
        end else if (w_grant_i) begin
            r_m_access   <= 1'b1;
            r_m_addr     <= i_addr;
            r_m_data_out <= '0;
            r_m_wr_en    <= 1'b0;
            r_m_bytesel  <= 2'b11;
        end else if (w_grant_d) begin
            r_m_access   <= 1'b1;
            r_m_addr     <= d_addr;
            r_m_data_out <= d_data_out;
            r_m_wr_en    <= d_wr_en;
            r_m_bytesel  <= d_bytesel;
        end else if (w_done) begin
            r_m_access   <= 1'b0;
            r_m_addr     <= '0;
            r_m_data_out <= '0;
            r_m_wr_en    <= 1'b0;
            r_m_bytesel  <= '0;
        end
    end

    // Acks are forwarded only to the current owner; stray m_ack pulses are dropped.
    assign i_ack      = (r_state == ST_SERVE_I) && m_ack;
    assign d_ack      = (r_state == ST_SERVE_D) && m_ack;
    assign i_data_in  = m_data_in;
    assign d_data_in  = m_data_in;

    assign m_access   = r_m_access;
    assign m_addr     = r_m_addr;
    assign m_data_out = r_m_data_out;
    assign m_wr_en    = r_m_wr_en;
    assign m_bytesel  = r_m_bytesel;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, corner-case
// sequences, then random traffic against a transaction-level reference model.
`timescale 1ns/1ps

module tb_mem_bus_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [18:0] i_addr;
    logic        i_access;
    logic        i_ack;
    logic [15:0] i_data_in;
    logic [18:0] d_addr;
    logic [15:0] d_data_out;
    logic        d_wr_en;
    logic [1:0]  d_bytesel;
    logic        d_lock;
    logic        d_access;
    logic        d_ack;
    logic [15:0] d_data_in;
    logic [18:0] m_addr;
    logic [15:0] m_data_out;
    logic        m_wr_en;
    logic [1:0]  m_bytesel;
    logic        m_access;
    logic        m_ack;
    logic [15:0] m_data_in;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_addr     (i_addr),
        .i_access   (i_access),
        .i_ack      (i_ack),
        .i_data_in  (i_data_in),
        .d_addr     (d_addr),
        .d_data_out (d_data_out),
        .d_wr_en    (d_wr_en),
        .d_bytesel  (d_bytesel),
        .d_lock     (d_lock),
        .d_access   (d_access),
        .d_ack      (d_ack),
        .d_data_in  (d_data_in),
        .m_addr     (m_addr),
        .m_data_out (m_data_out),
        .m_wr_en    (m_wr_en),
        .m_bytesel  (m_bytesel),
        .m_access   (m_access),
        .m_ack      (m_ack),
        .m_data_in  (m_data_in)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        i_access = 1'b0;
        d_access = 1'b0;
        d_lock   = 1'b0;
        m_ack    = 1'b0;
    endtask

    task automatic check_bus_zero(input string tag);
        check({tag, " bus zero"}, {m_access, m_wr_en, m_bytesel, m_addr, m_data_out}, 64'd0);
    endtask

    // Waits (bounded) for a grant, acks it at once, reports {i_ack, d_ack}.
    task automatic run_txn(input string tag, output logic [1:0] who);
        for (int k = 0; k < 8 && !m_access; k++) step();
        check({tag, " grant seen"}, m_access, 1'b1);
        m_ack = 1'b1;
        #1;
        who = {i_ack, d_ack};
        step();
        m_ack = 1'b0;
    endtask

    typedef struct {
        logic        i_req;
        logic        d_req;
        logic [18:0] ia;
        logic [18:0] da;
        logic [15:0] dd;
        logic        dwr;
        logic [1:0]  dbs;
        logic        exp_d;
        logic [18:0] exp_addr;
        logic [15:0] exp_dout;
        logic        exp_wr;
        logic [1:0]  exp_bs;
    } vec_t;

    vec_t vecs[5];

    typedef enum {OWN_NONE, OWN_I, OWN_D} owner_e;

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0]  who;
        logic [15:0] md;
        owner_e      own;
        bit          locked;
        int          streak;
        logic [18:0] e_addr;
        logic [15:0] e_dout;
        logic        e_wr;
        logic [1:0]  e_bs;
        int          mem_wait;
        bit          i_done;
        bit          d_done;
        int          r;

        vecs[0] = '{1'b1, 1'b0, 19'h0ABCD, 19'h00000, 16'h1234, 1'b1, 2'b01,
                    1'b0, 19'h0ABCD, 16'h0000, 1'b0, 2'b11};
        vecs[1] = '{1'b0, 1'b1, 19'h11111, 19'h12345, 16'h1111, 1'b0, 2'b11,
                    1'b1, 19'h12345, 16'h1111, 1'b0, 2'b11};
        vecs[2] = '{1'b0, 1'b1, 19'h00000, 19'h7FFFF, 16'hCAFE, 1'b1, 2'b01,
                    1'b1, 19'h7FFFF, 16'hCAFE, 1'b1, 2'b01};
        vecs[3] = '{1'b1, 1'b1, 19'h22222, 19'h00001, 16'h5A5A, 1'b1, 2'b10,
                    1'b1, 19'h00001, 16'h5A5A, 1'b1, 2'b10};
        vecs[4] = '{1'b1, 1'b0, 19'h7FFFF, 19'h33333, 16'hFFFF, 1'b1, 2'b00,
                    1'b0, 19'h7FFFF, 16'h0000, 1'b0, 2'b11};

        // Reset state, with a stray m_ack present
        reset_n = 1'b0;
        idle_all();
        i_addr = '0; d_addr = '0; d_data_out = '0; d_wr_en = 1'b0; d_bytesel = '0;
        m_data_in = 16'h0000;
        m_ack = 1'b1;
        #1;
        check_bus_zero("reset");
        check("reset acks", {i_ack, d_ack}, 2'b00);
        m_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();
        check_bus_zero("post reset");

        // Vector table: one transaction each from a clean IDLE
        foreach (vecs[n]) begin
            idle_all();
            step();
            i_access = vecs[n].i_req; i_addr = vecs[n].ia;
            d_access = vecs[n].d_req; d_addr = vecs[n].da; d_data_out = vecs[n].dd;
            d_wr_en = vecs[n].dwr; d_bytesel = vecs[n].dbs;
            step();
            check($sformatf("vec%0d m_access", n), m_access, 1'b1);
            check($sformatf("vec%0d fields", n), {m_addr, m_data_out, m_wr_en, m_bytesel},
                  {vecs[n].exp_addr, vecs[n].exp_dout, vecs[n].exp_wr, vecs[n].exp_bs});
            md = 16'($urandom);
            m_data_in = md;
            m_ack = 1'b1;
            #1;
            check($sformatf("vec%0d ack route", n), {i_ack, d_ack}, vecs[n].exp_d ? 2'b01 : 2'b10);
            check($sformatf("vec%0d rdata", n), {i_data_in, d_data_in}, {md, md});
            step();
            idle_all();
            check_bus_zero($sformatf("vec%0d after ack", n));
        end

        // Single D read with 3-cycle memory latency
        idle_all();
        step();
        d_access = 1'b1; d_addr = 19'h12345; d_wr_en = 1'b0; d_bytesel = 2'b11; d_data_out = '0;
        step();
        check("dread grant", {m_access, m_addr}, {1'b1, 19'h12345});
        for (int k = 0; k < 2; k++) begin
            step();
            check("dread wait", {m_access, i_ack, d_ack}, 3'b100);
        end
        step();
        m_data_in = 16'hBEEF;
        m_ack = 1'b1;
        #1;
        check("dread ack", {i_ack, d_ack, d_data_in}, {2'b01, 16'hBEEF});
        step();
        m_ack = 1'b0; d_access = 1'b0;
        check("dread addr cleared", {m_access, m_addr}, 20'd0);

        // Starvation: D wins LIMIT times, then I, then D again (counter cleared)
        idle_all();
        step();
        i_access = 1'b1; i_addr = 19'h01000;
        d_access = 1'b1; d_addr = 19'h02000; d_wr_en = 1'b0; d_bytesel = 2'b11;
        step();
        for (int t = 0; t < 6; t++) begin
            run_txn($sformatf("starve%0d", t), who);
            check($sformatf("starve owner %0d", t), who, (t == LIMIT) ? 2'b10 : 2'b01);
        end
        idle_all();

        // Locked split write holds off I until the lock drops
        step();
        i_access = 1'b1; i_addr = 19'h04000;
        d_access = 1'b1; d_lock = 1'b1; d_wr_en = 1'b1;
        d_addr = 19'h00100; d_bytesel = 2'b10; d_data_out = 16'hAA00;
        step();
        check("lock1 fields", {m_access, m_addr, m_wr_en, m_bytesel, m_data_out},
              {1'b1, 19'h00100, 1'b1, 2'b10, 16'hAA00});
        m_ack = 1'b1;
        #1;
        check("lock1 ack", {i_ack, d_ack}, 2'b01);
        step();
        m_ack = 1'b0;
        d_addr = 19'h00101; d_bytesel = 2'b01; d_data_out = 16'h00BB;
        step();
        check("lock2 fields", {m_access, m_addr, m_wr_en, m_bytesel, m_data_out},
              {1'b1, 19'h00101, 1'b1, 2'b01, 16'h00BB});
        m_ack = 1'b1;
        #1;
        check("lock2 ack", {i_ack, d_ack}, 2'b01);
        step();
        m_ack = 1'b0; d_access = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            check("lock hold no grant", m_access, 1'b0);
        end
        d_lock = 1'b0;
        step();
        check("lock release idle", m_access, 1'b0);
        step();
        check("lock then I", {m_access, m_addr, m_wr_en, m_bytesel}, {1'b1, 19'h04000, 1'b0, 2'b11});
        m_ack = 1'b1;
        #1;
        check("lock I ack", {i_ack, d_ack}, 2'b10);
        step();
        idle_all();

        // Requester fields change mid-transaction; bus stays frozen
        step();
        d_access = 1'b1; d_addr = 19'h00010; d_wr_en = 1'b1; d_bytesel = 2'b11; d_data_out = 16'h1234;
        step();
        check("freeze grant", m_addr, 19'h00010);
        d_addr = 19'h00020; d_data_out = 16'h4321; d_wr_en = 1'b0; d_bytesel = 2'b01;
        for (int k = 0; k < 2; k++) begin
            step();
            check("freeze hold", {m_addr, m_data_out, m_wr_en, m_bytesel}, {19'h00010, 16'h1234, 1'b1, 2'b11});
        end
        m_ack = 1'b1;
        #1;
        check("freeze at ack", {d_ack, m_addr}, {1'b1, 19'h00010});
        step();
        idle_all();
        check_bus_zero("freeze after ack");

        // Spurious m_ack in IDLE
        step();
        m_ack = 1'b1;
        #1;
        check("spurious acks", {i_ack, d_ack}, 2'b00);
        step();
        check("spurious no grant", m_access, 1'b0);
        m_ack = 1'b0;
        i_access = 1'b1; i_addr = 19'h00555;
        step();
        check("after spurious grant", {m_access, m_addr}, {1'b1, 19'h00555});
        m_ack = 1'b1;
        #1;
        check("after spurious ack", {i_ack, d_ack}, 2'b10);
        step();
        idle_all();

        // Asynchronous reset during SERVE_I
        step();
        i_access = 1'b1; i_addr = 19'h3C3C3;
        step();
        check("rst grant", m_access, 1'b1);
        #2;
        reset_n = 1'b0;
        m_ack = 1'b1;
        #1;
        check_bus_zero("rst async");
        check("rst acks", {i_ack, d_ack}, 2'b00);
        step();
        m_ack = 1'b0;
        check_bus_zero("rst held");
        reset_n = 1'b1;
        step();
        check("rst regrant", {m_access, m_addr, m_wr_en, m_bytesel}, {1'b1, 19'h3C3C3, 1'b0, 2'b11});
        m_ack = 1'b1;
        #1;
        check("rst regrant ack", {i_ack, d_ack}, 2'b10);
        step();
        idle_all();
        step();
        step();

        // Random traffic against a transaction-level model
        own = OWN_NONE; locked = 1'b0; streak = 0;
        e_addr = '0; e_dout = '0; e_wr = 1'b0; e_bs = '0;
        mem_wait = 0; i_done = 1'b0; d_done = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (i_done) begin
                i_access = ($urandom_range(0, 1) == 1);
                i_addr = 19'($urandom);
            end else if (!i_access && $urandom_range(0, 3) == 0) begin
                i_access = 1'b1;
                i_addr = 19'($urandom);
            end
            if (d_done) d_access = 1'b0;
            if (!d_access) begin
                r = $urandom_range(0, 3);
                if (d_lock && r == 0) begin
                    d_lock = 1'b0;
                end else if ((d_lock && r == 1) || (!d_lock && r == 0)) begin
                    d_access = 1'b1;
                    d_addr = 19'($urandom);
                    d_data_out = 16'($urandom);
                    d_wr_en = 1'($urandom);
                    d_bytesel = 2'($urandom);
                    d_lock = ($urandom_range(0, 3) == 0);
                end
            end
            m_ack = 1'b0;
            if (m_access) begin
                if (mem_wait == 0) begin
                    m_ack = 1'b1;
                    mem_wait = $urandom_range(0, 3);
                end else begin
                    mem_wait--;
                end
            end else begin
                m_ack = ($urandom_range(0, 7) == 0);
            end
            m_data_in = 16'($urandom);
            #1;

            check("rnd m_access", m_access, own != OWN_NONE);
            if (own == OWN_NONE)
                check_bus_zero("rnd idle");
            else
                check("rnd fields", {m_addr, m_data_out, m_wr_en, m_bytesel}, {e_addr, e_dout, e_wr, e_bs});
            check("rnd acks", {i_ack, d_ack}, {own == OWN_I && m_ack, own == OWN_D && m_ack});
            check("rnd rdata", {i_data_in, d_data_in}, {m_data_in, m_data_in});
            i_done = i_ack;
            d_done = d_ack;

            // Model: what the coming edge does to the bus
            if (own != OWN_NONE) begin
                if (m_ack) begin
                    if (own == OWN_D && d_lock) locked = 1'b1;
                    own = OWN_NONE;
                end
            end else if (locked) begin
                if (d_access) begin
                    own = OWN_D; locked = 1'b0;
                    e_addr = d_addr; e_dout = d_data_out; e_wr = d_wr_en; e_bs = d_bytesel;
                    if (i_access) streak = (streak + 1 > LIMIT) ? LIMIT : streak + 1;
                end else if (!d_lock) begin
                    locked = 1'b0;
                end
            end else begin
                if (!i_access) streak = 0;
                if (d_access && (!i_access || streak < LIMIT)) begin
                    own = OWN_D;
                    e_addr = d_addr; e_dout = d_data_out; e_wr = d_wr_en; e_bs = d_bytesel;
                    if (i_access) streak = (streak + 1 > LIMIT) ? LIMIT : streak + 1;
                end else if (i_access) begin
                    own = OWN_I;
                    e_addr = i_addr; e_dout = '0; e_wr = 1'b0; e_bs = 2'b11;
                    streak = 0;
                end
            end
        end

        idle_all();
        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter that shares the CPU's single external memory bus between the instruction prefetch unit (port I) and the load/store unit (port D). It latches one requester's address, data, write-enable and byte mask onto registered bus outputs and holds the grant until the memory side acknowledges. It steers the acknowledge back to the owner. It sits between the CPU core's two memory masters and the memory/cache subsystem.

## Interface
Parameters:
- STARVE_LIMIT, 4: number of consecutive D grants allowed while I is waiting before I is forced to win (1..15).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- i_addr  in  19  port I word address [19:1]
- i_access  in  1  port I request, held until i_ack
- i_ack  out  1  port I acknowledge (combinational)
- i_data_in  out  16  read data to port I (= m_data_in)
- d_addr  in  19  port D word address [19:1]
- d_data_out  in  16  port D write data
- d_wr_en  in  1  port D write (1) / read (0)
- d_bytesel  in  2  port D byte mask
- d_lock  in  1  port D atomic lock for split (unaligned) accesses
- d_access  in  1  port D request, held until d_ack
- d_ack  out  1  port D acknowledge (combinational)
- d_data_in  out  16  read data to port D (= m_data_in)
- m_addr  out  19  bus word address
- m_data_out  out  16  bus write data
- m_wr_en  out  1  bus write enable
- m_bytesel  out  2  bus byte mask
- m_access  out  1  bus request
- m_ack  in  1  bus acknowledge, one-cycle pulse
- m_data_in  in  16  bus read data, valid with m_ack

## Operation
- Port I is read-only: on an I grant, m_wr_en=0 and m_bytesel=2'b11.
- States: IDLE, SERVE_I, SERVE_D, HOLD_D.
- IDLE: arbitration is evaluated every cycle.
  - D wins if d_access and (!i_access or starve_cnt < STARVE_LIMIT). Otherwise I wins if i_access.
  - The winner's fields are registered onto m_* and m_access is set to 1. The state moves to SERVE_I or SERVE_D.
- SERVE_x:
  - m_* outputs are frozen; requester input changes are ignored.
  - x_ack = m_ack.
  - On m_ack: m_access, m_wr_en, m_addr, m_data_out and m_bytesel are cleared. SERVE_I goes to IDLE. SERVE_D goes to HOLD_D if d_lock=1, else IDLE.
- HOLD_D:
  - Only D may be granted; i_access is ignored.
  - d_access goes to SERVE_D with the same register load as IDLE.
  - d_lock=0 with no d_access goes to IDLE.
  - d_access has priority over a same-cycle d_lock drop.
- starve_cnt (4 bits):
  - Increments on each D grant made while i_access=1, saturating at STARVE_LIMIT.
  - Clears on an I grant, or on any IDLE cycle with i_access=0.
  - D grants from HOLD_D also count.
- i_ack and d_ack are never both 1. m_ack in IDLE/HOLD_D is ignored and not forwarded.
- A requester that drops access before its ack does not abort the transaction. The bus cycle completes and the ack is still pulsed.

## Timing
- Reset (async assert, sync release): state IDLE, starve_cnt=0, m_access=0, m_wr_en=0, m_addr=0, m_data_out=0, m_bytesel=0. i_ack=d_ack=0.
- Grant latency: request high at edge N in IDLE → m_access=1 after edge N (1 cycle).
- Ack path: zero-cycle combinational forward. The requester samples x_ack and m_data_in on the same edge on which the arbiter leaves SERVE_x.
- Back-to-back: the next grant is evaluated in the first IDLE/HOLD_D cycle after the ack edge. Minimum bus idle gap is 1 cycle between transactions.
- Single-transaction cost: 1 grant cycle + memory latency.
- Reset mid-transaction: m_access drops immediately (async). The pending ack is lost; requesters are reset by the same reset.

## Test plan
- Single D read, addr 19'h12345, m_ack 3 cycles after m_access → m_access high 1 cycle after d_access, d_ack=1 with d_data_in=m_data_in=16'hBEEF, m_addr=0 next cycle.
- i_access and d_access raised together, STARVE_LIMIT=4, D re-requests continuously → D granted 4 times, then I granted on the 5th arbitration; starve_cnt=0 afterwards.
- D write with d_lock=1, split into two transactions (bytesel 2'b10 then 2'b01) while i_access held → I not granted until d_lock=0 after the second d_ack.
- Requester inputs changed during SERVE_D (d_addr 19'h00010→19'h00020) → m_addr stays 19'h00010 until m_ack.
- Spurious m_ack in IDLE → i_ack=d_ack=0, no state change.
- reset_n pulsed low during SERVE_I → m_access=0 asynchronously, all m_* zero, state IDLE, next i_access granted normally after release.
